// File: rtl/ex_issue_stage.sv
// ID/EX issue stage: two-entry skid buffer in front of the lane ALU, with RAW handling.
// Define FORWARDING_EN for EX/MEM and MEM/WB forwarding; without it, RAW hazards stall the head.
module ex_issue_stage #(
    parameter int N     = 16,
    parameter int REG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_select,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [REG_W-1:0] in_rs1,
    input  logic [REG_W-1:0] in_rs2,
    input  logic [REG_W-1:0] in_rd,
    input  logic             in_we,
    input  logic             flush,
    input  logic             out_ready,
    input  logic             exm_we,
    input  logic [REG_W-1:0] exm_rd,
    input  logic [N-1:0]     exm_result,
    input  logic             wb_we,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [N-1:0]     wb_result,
    output logic             out_valid,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [3:0]       alu_select,
    output logic [REG_W-1:0] out_rd,
    output logic             out_we,
    output logic             hazard_stall
);
    typedef struct packed {
        logic [3:0]       sel;
        logic [N-1:0]     a;
        logic [N-1:0]     b;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             we;
    } op_t;

    op_t  head, skid, in_op;
    logic head_v, skid_v;
    logic accept, retire;

    assign in_op  = '{sel: in_select, a: in_a, b: in_b, rs1: in_rs1, rs2: in_rs2, rd: in_rd, we: in_we};
    assign in_ready = ~skid_v;
    assign accept = in_valid & in_ready;
    assign retire = out_valid & out_ready;

    // Skid is only filled while the head is occupied and not leaving, so in_ready
    // drops before a third op could arrive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_v <= 1'b0;
            skid_v <= 1'b0;
            head   <= '0;
            skid   <= '0;
        end else if (flush) begin
            head_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (retire || !head_v) begin
            if (skid_v) begin
                head   <= skid;
                head_v <= 1'b1;
                skid_v <= 1'b0;
            end else if (accept) begin
                head   <= in_op;
                head_v <= 1'b1;
            end else begin
                head_v <= 1'b0;
            end
        end else if (accept) begin
            skid   <= in_op;
            skid_v <= 1'b1;
        end
    end

    logic [N-1:0] opnd_a, opnd_b;

`ifdef FORWARDING_EN
    function automatic logic [N-1:0] fwd(input logic [REG_W-1:0] tag, input logic [N-1:0] cap);
        if (tag != '0 && exm_we && exm_rd == tag)     return exm_result;
        else if (tag != '0 && wb_we && wb_rd == tag)  return wb_result;
        else                                          return cap;
    endfunction

    assign opnd_a       = fwd(head.rs1, head.a);
    assign opnd_b       = fwd(head.rs2, head.b);
    assign hazard_stall = 1'b0;
`else
    function automatic logic raw(input logic [REG_W-1:0] tag);
        return (tag != '0) && ((exm_we && exm_rd == tag) || (wb_we && wb_rd == tag));
    endfunction

    logic unused_fwd_results;
    assign unused_fwd_results = ^{exm_result, wb_result};
    assign opnd_a       = head.a;
    assign opnd_b       = head.b;
    assign hazard_stall = head_v & (raw(head.rs1) | raw(head.rs2));
`endif

    assign out_valid  = head_v & ~hazard_stall;
    assign alu_a      = opnd_a;
    assign alu_b      = opnd_b;
    assign alu_select = out_valid ? head.sel : 4'b0000;
    assign out_we     = out_valid & head.we;
    assign out_rd     = head.rd;
endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed self-checking bench for ex_issue_stage (stalling build by default, FORWARDING_EN optional).
module tb_ex_issue_stage;
    localparam int N = 16;
    localparam int REG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, in_we, flush, out_ready;
    logic [3:0]       in_select, alu_select;
    logic [N-1:0]     in_a, in_b, exm_result, wb_result, alu_a, alu_b;
    logic [REG_W-1:0] in_rs1, in_rs2, in_rd, exm_rd, wb_rd, out_rd;
    logic             exm_we, wb_we, out_valid, out_we, hazard_stall;

    int errors = 0;
    int checks = 0;

    ex_issue_stage #(.N(N), .REG_W(REG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_select(in_select),
        .in_a(in_a), .in_b(in_b), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_we(in_we),
        .flush(flush), .out_ready(out_ready),
        .exm_we(exm_we), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_result(wb_result),
        .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
        .out_rd(out_rd), .out_we(out_we), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                            input logic [REG_W-1:0] rd);
        in_valid  = 1'b1;
        in_select = 4'b1000;
        in_a      = a;
        in_b      = b;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_rd     = rd;
        in_we     = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_select = 0; in_a = 0; in_b = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_we = 0;
        flush = 0; out_ready = 1;
        exm_we = 0; exm_rd = 0; exm_result = 0; wb_we = 0; wb_rd = 0; wb_result = 0;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_alu_sel", alu_select, 0);
        chk("rst_out_we", out_we, 0);
        chk("rst_hazard", hazard_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back ADDs, latency 1, one issue per cycle
        tick;
        drive_op(16'h0011, 16'h0022, 0, 0, 4'd1);
        tick;
        chk("b2b_v0", out_valid, 1);
        chk("b2b_a0", alu_a, 16'h0011);
        chk("b2b_b0", alu_b, 16'h0022);
        chk("b2b_sel0", alu_select, 4'b1000);
        chk("b2b_rd0", out_rd, 1);
        chk("b2b_we0", out_we, 1);
        chk("b2b_rdy0", in_ready, 1);
        drive_op(16'h0033, 16'h0044, 0, 0, 4'd2);
        tick;
        chk("b2b_v1", out_valid, 1);
        chk("b2b_a1", alu_a, 16'h0033);
        chk("b2b_rdy1", in_ready, 1);
        in_valid = 0;
        tick;
        chk("b2b_idle_v", out_valid, 0);
        chk("b2b_idle_sel", alu_select, 0);
        chk("b2b_idle_we", out_we, 0);

        // backpressure: two ops held, third refused, then in-order drain
        out_ready = 0;
        drive_op(16'h0044, 16'h0001, 0, 0, 4'd2);
        tick;
        chk("bp_v", out_valid, 1);
        chk("bp_rdy1", in_ready, 1);
        drive_op(16'h0055, 16'h0002, 0, 0, 4'd3);
        tick;
        chk("bp_rdy_full", in_ready, 0);
        drive_op(16'h0066, 16'h0003, 0, 0, 4'd4);
        tick;
        chk("bp_rdy_still", in_ready, 0);
        chk("bp_head_held", alu_a, 16'h0044);
        in_valid = 0;
        out_ready = 1;
        tick;
        chk("bp_second", alu_a, 16'h0055);
        chk("bp_second_rd", out_rd, 3);
        chk("bp_rdy_free", in_ready, 1);
        tick;
        chk("bp_drained", out_valid, 0);

`ifdef FORWARDING_EN
        exm_we = 1; exm_rd = 3; exm_result = 16'h00AA;
        wb_we = 1; wb_rd = 3; wb_result = 16'h0055;
        out_ready = 0;
        drive_op(16'h1111, 16'h2222, 4'd3, 4'd0, 4'd6);
        tick;
        in_valid = 0;
        chk("fwd_exm_wins", alu_a, 16'h00AA);
        chk("fwd_no_stall", hazard_stall, 0);
        chk("fwd_b_cap", alu_b, 16'h2222);
        exm_we = 0;
        #1;
        chk("fwd_wb", alu_a, 16'h0055);
        wb_we = 0;
        #1;
        chk("fwd_cap", alu_a, 16'h1111);
        out_ready = 1;
        tick;
        chk("fwd_retired", out_valid, 0);
`else
        wb_we = 1; wb_rd = 5; wb_result = 16'h0BAD;
        drive_op(16'h0007, 16'h0008, 4'd0, 4'd5, 4'd6);
        tick;
        in_valid = 0;
        chk("hz_stall", hazard_stall, 1);
        chk("hz_out_valid", out_valid, 0);
        chk("hz_sel_nop", alu_select, 0);
        chk("hz_we", out_we, 0);
        tick;
        chk("hz_still", hazard_stall, 1);
        wb_we = 0;
        #1;
        chk("hz_clear_v", out_valid, 1);
        chk("hz_clear_b", alu_b, 16'h0008);
        chk("hz_clear_sel", alu_select, 4'b1000);
        tick;
        chk("hz_retired", out_valid, 0);
        // tag 0 is never hazarded
        exm_we = 1; exm_rd = 0;
        drive_op(16'h0009, 16'h000A, 4'd0, 4'd0, 4'd1);
        tick;
        in_valid = 0;
        chk("hz_tag0", out_valid, 1);
        tick;
        exm_we = 0;
`endif

        // flush with both entries full and a new op offered
        out_ready = 0;
        drive_op(16'h0101, 16'h0, 0, 0, 4'd1);
        tick;
        drive_op(16'h0202, 16'h0, 0, 0, 4'd2);
        tick;
        chk("fl_full", in_ready, 0);
        drive_op(16'h0303, 16'h0, 0, 0, 4'd3);
        flush = 1;
        tick;
        flush = 0;
        chk("fl_v", out_valid, 0);
        chk("fl_rdy", in_ready, 1);
        in_valid = 0;
        tick;
        chk("fl_dropped", out_valid, 0);

        // async reset mid-stream with two ops held
        drive_op(16'h0A0A, 16'h0B0B, 0, 0, 4'd7);
        tick;
        drive_op(16'h0C0C, 16'h0D0D, 0, 0, 4'd8);
        tick;
        in_valid = 0;
        chk("ar_pre_full", in_ready, 0);
        #2;
        rst_n = 0;
        #1;
        chk("ar_v", out_valid, 0);
        chk("ar_rdy", in_ready, 1);
        chk("ar_a", alu_a, 0);
        chk("ar_b", alu_b, 0);
        chk("ar_sel", alu_select, 0);
        chk("ar_rd", out_rd, 0);
        chk("ar_we", out_we, 0);
        chk("ar_hz", hazard_stall, 0);
        @(negedge clk);
        rst_n = 1;
        tick;
        chk("ar_after", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
